// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file for a single-hart RV32 core.
//
// Implements the ID registers, mstatus/mstatush, misa, mie/mip, mtvec,
// mcountinhibit, mscratch, mepc, mcause, mtval and the 64-bit mcycle and
// minstret counters. An access is accepted in one cycle and answered on the
// next (csr_rvalid/csr_rdata/csr_illegal). Trap entry and mret update
// mstatus/mepc/mcause/mtval directly and take priority over software writes.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   csr_valid, csr_addr,       access request: address, op (01 RW, 10 RS,
//   csr_op, csr_nowrite,       11 RC, 00 none), write suppression, operand
//   csr_wdata
//   csr_rdata, csr_rvalid,     registered response, pulse one cycle later
//   csr_illegal
//   instr_retire               one instruction retired this cycle
//   trap_valid, trap_cause,    trap entry with cause, faulting pc and tval
//   trap_pc, trap_val
//   mret                       return from trap
//   irq_ext, irq_timer, irq_sw interrupt lines (mip bits 11, 7, 3)
//   mtvec_o, mepc_o            current mtvec and mepc
//   irq_pending                enabled interrupt pending and mstatus.MIE set
module csr_unit #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] VENDOR_ID = 32'h0,
    parameter logic [31:0] ARCH_ID   = 32'h0,
    parameter logic [31:0] IMP_ID    = 32'h0,
    parameter logic [31:0] HART_ID   = 32'h0,
    parameter logic [31:0] MISA_VAL  = 32'h40000100,
    parameter logic [31:0] MIE_MASK  = 32'h00000888
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_valid,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic            csr_nowrite,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_rvalid,
    output logic            csr_illegal,
    input  logic            instr_retire,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_val,
    input  logic            mret,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_sw,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            irq_pending
);

    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic            inhibit_cy;
    logic            inhibit_ir;
    logic [63:0]     mcycle_q;
    logic [63:0]     minstret_q;

    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] mip_rd;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] wval;
    logic            mapped;
    logic            req;
    logic            wr_req;
    logic            illegal;
    logic            sw_we;
    logic [63:0]     cycle_inc;
    logic [63:0]     instret_inc;

    // MPP is hardwired to machine mode (2'b11).
    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
    assign mip_rd     = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};

    assign mtvec_o     = mtvec_q;
    assign mepc_o      = mepc_q;
    assign irq_pending = (|(mip_rd & mie_q)) & mstatus_mie;

    // Read mux; anything not listed here is an unmapped address.
    always_comb begin
        rd_val = '0;
        mapped = 1'b1;
        case (csr_addr)
            12'hF11: rd_val = VENDOR_ID;
            12'hF12: rd_val = ARCH_ID;
            12'hF13: rd_val = IMP_ID;
            12'hF14: rd_val = HART_ID;
            12'h300: rd_val = mstatus_rd;
            12'h301: rd_val = MISA_VAL;
            12'h304: rd_val = mie_q;
            12'h305: rd_val = mtvec_q;
            12'h310: rd_val = '0;
            12'h320: rd_val = {29'b0, inhibit_ir, 1'b0, inhibit_cy};
            12'h340: rd_val = mscratch_q;
            12'h341: rd_val = mepc_q;
            12'h342: rd_val = mcause_q;
            12'h343: rd_val = mtval_q;
            12'h344: rd_val = mip_rd;
            12'hB00: rd_val = mcycle_q[31:0];
            12'hB80: rd_val = mcycle_q[63:32];
            12'hB02: rd_val = minstret_q[31:0];
            12'hB82: rd_val = minstret_q[63:32];
            12'hB03, 12'hB83, 12'h323: rd_val = '0;
            default: mapped = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = rd_val | csr_wdata;
            2'b11:   wval = rd_val & ~csr_wdata;
            default: wval = rd_val;
        endcase
    end

    assign req     = csr_valid && (csr_op != 2'b00);
    assign wr_req  = req && !csr_nowrite;
    // addr[11:10]==11 marks the read-only CSR space.
    assign illegal = !mapped || (wr_req && (csr_addr[11:10] == 2'b11));
    // Trap entry and mret own the state this cycle; the access still answers.
    assign sw_we   = wr_req && !illegal && !trap_valid && !mret;

    assign cycle_inc   = mcycle_q + {63'b0, ~inhibit_cy};
    assign instret_inc = minstret_q + {63'b0, instr_retire & ~inhibit_ir};

    // ---- response register and state update (read data is pre-write value) ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csr_rdata    <= '0;
            csr_rvalid   <= 1'b0;
            csr_illegal  <= 1'b0;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= '0;
            mtvec_q      <= '0;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            inhibit_cy   <= 1'b0;
            inhibit_ir   <= 1'b0;
            mcycle_q     <= '0;
            minstret_q   <= '0;
        end else begin
            csr_rvalid  <= req;
            csr_illegal <= req && illegal;
            csr_rdata   <= (req && !illegal) ? rd_val : '0;
            mcycle_q    <= cycle_inc;
            minstret_q  <= instret_inc;

            if (trap_valid) begin
                mepc_q       <= trap_pc & ~32'h3;
                mcause_q     <= trap_cause;
                mtval_q      <= trap_val;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (sw_we) begin
                case (csr_addr)
                    12'h300: begin
                        mstatus_mie  <= wval[3];
                        mstatus_mpie <= wval[7];
                    end
                    12'h304: mie_q      <= wval & MIE_MASK;
                    12'h305: mtvec_q    <= wval & ~32'h2;
                    12'h320: begin
                        inhibit_cy <= wval[0];
                        inhibit_ir <= wval[2];
                    end
                    12'h340: mscratch_q <= wval;
                    12'h341: mepc_q     <= wval & ~32'h3;
                    12'h342: mcause_q   <= wval;
                    12'h343: mtval_q    <= wval;
                    // A written half takes the written value; the other half
                    // keeps its normal (possibly incremented) next value.
                    12'hB00: mcycle_q   <= {cycle_inc[63:32], wval};
                    12'hB80: mcycle_q   <= {wval, cycle_inc[31:0]};
                    12'hB02: minstret_q <= {instret_inc[63:32], wval};
                    12'hB82: minstret_q <= {wval, instret_inc[31:0]};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
module tb_csr_unit;

    localparam logic [31:0] P_VENDOR = 32'hCAFE0001;
    localparam logic [31:0] P_ARCH   = 32'h00000022;
    localparam logic [31:0] P_IMP    = 32'h00000333;
    localparam logic [31:0] P_HART   = 32'h00000007;
    localparam logic [31:0] P_MISA   = 32'h40000100;
    localparam logic [31:0] P_MASK   = 32'h00000888;

    logic        clk;
    logic        rst_n;
    logic        csr_valid;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic        csr_nowrite;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        csr_illegal;
    logic        instr_retire;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_sw;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        irq_pending;

    int checks;
    int failures;

    csr_unit #(
        .XLEN(32), .VENDOR_ID(P_VENDOR), .ARCH_ID(P_ARCH), .IMP_ID(P_IMP),
        .HART_ID(P_HART), .MISA_VAL(P_MISA), .MIE_MASK(P_MASK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .csr_valid(csr_valid), .csr_addr(csr_addr),
        .csr_op(csr_op), .csr_nowrite(csr_nowrite), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid), .csr_illegal(csr_illegal),
        .instr_retire(instr_retire), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_val(trap_val), .mret(mret), .irq_ext(irq_ext),
        .irq_timer(irq_timer), .irq_sw(irq_sw), .mtvec_o(mtvec_o), .mepc_o(mepc_o),
        .irq_pending(irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: architectural CSR state as plain variables.
    // ------------------------------------------------------------------
    logic        m_mie, m_mpie, m_cy, m_ir;
    logic [31:0] m_mier, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cycle, m_instret;
    logic        exp_rvalid, exp_illegal;
    logic [31:0] exp_rdata;

    function automatic logic [31:0] m_mip();
        return (irq_ext ? 32'h800 : 32'h0) + (irq_timer ? 32'h80 : 32'h0) + (irq_sw ? 32'h8 : 32'h0);
    endfunction

    function automatic logic m_irq();
        return ((m_mip() & m_mier) != 32'h0) && m_mie;
    endfunction

    // {mapped, value}
    function automatic logic [32:0] m_read(input logic [11:0] a);
        case (a)
            12'hF11: return {1'b1, P_VENDOR};
            12'hF12: return {1'b1, P_ARCH};
            12'hF13: return {1'b1, P_IMP};
            12'hF14: return {1'b1, P_HART};
            12'h300: return {1'b1, 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0)};
            12'h301: return {1'b1, P_MISA};
            12'h304: return {1'b1, m_mier};
            12'h305: return {1'b1, m_mtvec};
            12'h310: return {1'b1, 32'h0};
            12'h320: return {1'b1, (m_ir ? 32'h4 : 32'h0) + (m_cy ? 32'h1 : 32'h0)};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
            12'h344: return {1'b1, m_mip()};
            12'hB00: return {1'b1, m_cycle[31:0]};
            12'hB80: return {1'b1, m_cycle[63:32]};
            12'hB02: return {1'b1, m_instret[31:0]};
            12'hB82: return {1'b1, m_instret[63:32]};
            12'hB03, 12'hB83, 12'h323: return {1'b1, 32'h0};
            default: return 33'h0;
        endcase
    endfunction

    // Advance one clock: predict the response from the model, update the
    // model, take the edge, then release the one-shot inputs.
    task automatic tick();
        logic [32:0] r;
        logic        rq, wr, ill;
        logic [31:0] old, nv;
        if (!rst_n) begin
            m_mie = 0; m_mpie = 0; m_cy = 0; m_ir = 0;
            m_mier = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
            m_cycle = 0; m_instret = 0;
            exp_rvalid = 0; exp_illegal = 0; exp_rdata = 0;
        end else begin
            r   = m_read(csr_addr);
            old = r[31:0];
            rq  = csr_valid && (csr_op != 2'b00);
            wr  = rq && !csr_nowrite;
            ill = !r[32] || (wr && (csr_addr[11:10] == 2'b11));
            case (csr_op)
                2'b01:   nv = csr_wdata;
                2'b10:   nv = old | csr_wdata;
                2'b11:   nv = old & ~csr_wdata;
                default: nv = old;
            endcase
            exp_rvalid  = rq;
            exp_illegal = rq && ill;
            exp_rdata   = (rq && !ill) ? old : 32'h0;
            m_cycle     = m_cycle + (m_cy ? 64'd0 : 64'd1);
            m_instret   = m_instret + ((instr_retire && !m_ir) ? 64'd1 : 64'd0);
            if (trap_valid) begin
                m_mepc = trap_pc & 32'hFFFFFFFC; m_mcause = trap_cause; m_mtval = trap_val;
                m_mpie = m_mie; m_mie = 0;
            end else if (mret) begin
                m_mie = m_mpie; m_mpie = 1;
            end else if (wr && !ill) begin
                case (csr_addr)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h304: m_mier = nv & P_MASK;
                    12'h305: m_mtvec = nv & 32'hFFFFFFFD;
                    12'h320: begin m_cy = nv[0]; m_ir = nv[2]; end
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & 32'hFFFFFFFC;
                    12'h342: m_mcause = nv;
                    12'h343: m_mtval = nv;
                    12'hB00: m_cycle[31:0] = nv;
                    12'hB80: m_cycle[63:32] = nv;
                    12'hB02: m_instret[31:0] = nv;
                    12'hB82: m_instret[63:32] = nv;
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
        csr_valid = 0; csr_op = 2'b00; csr_nowrite = 0;
        trap_valid = 0; mret = 0; instr_retire = 0;
    endtask

    task automatic access(input logic [11:0] a, input logic [1:0] op, input logic nw, input logic [31:0] d);
        csr_valid = 1; csr_addr = a; csr_op = op; csr_nowrite = nw; csr_wdata = d;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 0;
        access(12'h340, 2'b01, 0, 32'h55);
        tick();
        checks++;
        if (csr_rvalid !== 1'b0 || csr_rdata !== 32'h0 || csr_illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs rvalid=%b rdata=%h illegal=%b required 0/0/0", csr_rvalid, csr_rdata, csr_illegal);
        end
        checks++;
        if (mtvec_o !== 32'h0 || mepc_o !== 32'h0 || irq_pending !== 1'b0) begin
            failures++;
            $display("FAIL reset_state mtvec=%h mepc=%h irq=%b required 0/0/0", mtvec_o, mepc_o, irq_pending);
        end
        rst_n = 1;
        access(12'hB00, 2'b10, 1, 32'h0);
        checks++;
        if (csr_rvalid !== 1'b1 || csr_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mcycle rvalid=%b rdata=%h required 1/00000000", csr_rvalid, csr_rdata);
        end
    endtask

    task automatic test_scratch();
        access(12'h340, 2'b01, 0, 32'hDEADBEEF);
        checks++;
        if (csr_rvalid !== 1'b1 || csr_rdata !== 32'h0 || csr_illegal !== 1'b0) begin
            failures++;
            $display("FAIL scratch_first rvalid=%b rdata=%h illegal=%b required 1/00000000/0", csr_rvalid, csr_rdata, csr_illegal);
        end
        access(12'h340, 2'b10, 1, 32'h0);
        checks++;
        if (csr_rvalid !== 1'b1 || csr_rdata !== 32'hDEADBEEF || csr_illegal !== 1'b0) begin
            failures++;
            $display("FAIL scratch_second rvalid=%b rdata=%h illegal=%b required 1/deadbeef/0", csr_rvalid, csr_rdata, csr_illegal);
        end
    endtask

    task automatic test_illegal();
        access(12'hF14, 2'b01, 0, 32'h5);
        checks++;
        if (csr_rvalid !== 1'b1 || csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin
            failures++;
            $display("FAIL ro_write rvalid=%b illegal=%b rdata=%h required 1/1/00000000", csr_rvalid, csr_illegal, csr_rdata);
        end
        access(12'hF14, 2'b10, 1, 32'h0);
        checks++;
        if (csr_illegal !== 1'b0 || csr_rdata !== P_HART) begin
            failures++;
            $display("FAIL hart_read illegal=%b rdata=%h required 0/%h", csr_illegal, csr_rdata, P_HART);
        end
        access(12'h7C0, 2'b10, 1, 32'h0);
        checks++;
        if (csr_rvalid !== 1'b1 || csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin
            failures++;
            $display("FAIL unmapped rvalid=%b illegal=%b rdata=%h required 1/1/00000000", csr_rvalid, csr_illegal, csr_rdata);
        end
    endtask

    task automatic test_fields();
        access(12'h305, 2'b01, 0, 32'hFFFFFFFF);
        checks++;
        if (mtvec_o !== 32'hFFFFFFFD) begin
            failures++;
            $display("FAIL mtvec_bit1 mtvec=%h required fffffffd", mtvec_o);
        end
        access(12'h341, 2'b01, 0, 32'h12345677);
        checks++;
        if (mepc_o !== 32'h12345674) begin
            failures++;
            $display("FAIL mepc_align mepc=%h required 12345674", mepc_o);
        end
        access(12'h304, 2'b01, 0, 32'hFFFFFFFF);
        access(12'h304, 2'b11, 0, 32'h0);
        checks++;
        if (csr_rdata !== P_MASK) begin
            failures++;
            $display("FAIL mie_mask rdata=%h required %h", csr_rdata, P_MASK);
        end
        access(12'h304, 2'b01, 0, 32'h0);
        access(12'h310, 2'b01, 0, 32'hFFFFFFFF);
        access(12'h310, 2'b10, 1, 32'h0);
        checks++;
        if (csr_rdata !== 32'h0 || csr_illegal !== 1'b0) begin
            failures++;
            $display("FAIL mstatush rdata=%h illegal=%b required 00000000/0", csr_rdata, csr_illegal);
        end
        irq_ext = 1; irq_sw = 1; irq_timer = 0;
        access(12'h344, 2'b01, 0, 32'h0);
        checks++;
        if (csr_rdata !== 32'h808 || csr_illegal !== 1'b0) begin
            failures++;
            $display("FAIL mip_read rdata=%h illegal=%b required 00000808/0", csr_rdata, csr_illegal);
        end
        irq_ext = 0; irq_sw = 0;
        access(12'h300, 2'b01, 0, 32'hFFFFFFFF);
        access(12'h300, 2'b01, 0, 32'h0);
        checks++;
        if (csr_rdata !== 32'h1888) begin
            failures++;
            $display("FAIL mstatus_bits rdata=%h required 00001888", csr_rdata);
        end
        csr_valid = 1; csr_addr = 12'h340; csr_op = 2'b00; csr_wdata = 32'h1;
        tick();
        checks++;
        if (csr_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL op_none rvalid=%b required 0", csr_rvalid);
        end
        access(12'h340, 2'b10, 1, 32'h0);
        checks++;
        if (csr_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL op_none_nowrite rdata=%h required deadbeef", csr_rdata);
        end
    endtask

    task automatic test_counter_wrap();
        access(12'h320, 2'b01, 0, 32'h1);
        access(12'hB00, 2'b01, 0, 32'hFFFFFFFF);
        access(12'hB80, 2'b01, 0, 32'hFFFFFFFF);
        access(12'h320, 2'b01, 0, 32'h0);
        access(12'hB00, 2'b10, 1, 32'h0);
        checks++;
        if (csr_rdata !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL cycle_preload rdata=%h required ffffffff", csr_rdata);
        end
        access(12'hB00, 2'b10, 1, 32'h0);
        checks++;
        if (csr_rdata !== 32'h0) begin
            failures++;
            $display("FAIL cycle_wrap_lo rdata=%h required 00000000", csr_rdata);
        end
        access(12'hB80, 2'b10, 1, 32'h0);
        checks++;
        if (csr_rdata !== 32'h0) begin
            failures++;
            $display("FAIL cycle_wrap_hi rdata=%h required 00000000", csr_rdata);
        end
        // minstret: counts retires only while IR=0
        access(12'hB02, 2'b01, 0, 32'h10);
        instr_retire = 1; tick();
        instr_retire = 1; tick();
        access(12'h320, 2'b01, 0, 32'h4);
        instr_retire = 1; tick();
        access(12'hB02, 2'b10, 1, 32'h0);
        checks++;
        if (csr_rdata !== 32'h12) begin
            failures++;
            $display("FAIL instret_count rdata=%h required 00000012", csr_rdata);
        end
        access(12'h320, 2'b01, 0, 32'h0);
    endtask

    task automatic test_irq_trap();
        irq_timer = 1;
        access(12'h300, 2'b01, 0, 32'h8);
        access(12'h304, 2'b01, 0, 32'h80);
        checks++;
        if (irq_pending !== 1'b1) begin
            failures++;
            $display("FAIL irq_set irq_pending=%b required 1", irq_pending);
        end
        trap_valid = 1; trap_cause = 32'h80000007; trap_pc = 32'h00001000; trap_val = 32'hABCD;
        tick();
        checks++;
        if (irq_pending !== 1'b0 || mepc_o !== 32'h00001000) begin
            failures++;
            $display("FAIL trap_entry irq_pending=%b mepc=%h required 0/00001000", irq_pending, mepc_o);
        end
        access(12'h300, 2'b10, 1, 32'h0);
        checks++;
        if (csr_rdata !== 32'h1880) begin
            failures++;
            $display("FAIL trap_mstatus rdata=%h required 00001880", csr_rdata);
        end
        access(12'h342, 2'b10, 1, 32'h0);
        checks++;
        if (csr_rdata !== 32'h80000007) begin
            failures++;
            $display("FAIL trap_mcause rdata=%h required 80000007", csr_rdata);
        end
        mret = 1; tick();
        access(12'h300, 2'b10, 1, 32'h0);
        checks++;
        if (csr_rdata !== 32'h1888 || irq_pending !== 1'b1) begin
            failures++;
            $display("FAIL mret rdata=%h irq_pending=%b required 00001888/1", csr_rdata, irq_pending);
        end
        irq_timer = 0;
    endtask

    task automatic test_trap_priority();
        trap_valid = 1; trap_cause = 32'h2; trap_pc = 32'h00002000; trap_val = 32'h0;
        access(12'h341, 2'b01, 0, 32'h100);
        checks++;
        if (csr_rvalid !== 1'b1 || csr_illegal !== 1'b0 || csr_rdata !== 32'h00001000) begin
            failures++;
            $display("FAIL trap_vs_write rvalid=%b illegal=%b rdata=%h required 1/0/00001000", csr_rvalid, csr_illegal, csr_rdata);
        end
        checks++;
        if (mepc_o !== 32'h00002000) begin
            failures++;
            $display("FAIL trap_wins mepc=%h required 00002000", mepc_o);
        end
    endtask

    task automatic test_random();
        logic [11:0] alist [0:23];
        alist = '{12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300, 12'h301, 12'h304, 12'h305,
                  12'h310, 12'h320, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00,
                  12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'h323, 12'h7C0, 12'h3A0};
        for (int i = 0; i < 400; i++) begin
            irq_ext = 1'($urandom_range(0, 1));
            irq_timer = 1'($urandom_range(0, 1));
            irq_sw = 1'($urandom_range(0, 1));
            csr_valid = ($urandom_range(0, 3) != 0);
            csr_addr = alist[$urandom_range(0, 23)];
            csr_op = 2'($urandom_range(0, 3));
            csr_nowrite = ($urandom_range(0, 3) == 0);
            csr_wdata = $urandom;
            instr_retire = 1'($urandom_range(0, 1));
            trap_valid = ($urandom_range(0, 15) == 0);
            mret = ($urandom_range(0, 15) == 0);
            trap_cause = $urandom; trap_pc = $urandom; trap_val = $urandom;
            tick();
            checks++;
            if (csr_rvalid !== exp_rvalid || (exp_rvalid && (csr_rdata !== exp_rdata || csr_illegal !== exp_illegal))) begin
                failures++;
                $display("FAIL rand_resp it=%0d rvalid=%b rdata=%h illegal=%b required %b/%h/%b", i, csr_rvalid, csr_rdata, csr_illegal, exp_rvalid, exp_rdata, exp_illegal);
            end
            checks++;
            if (irq_pending !== m_irq() || mtvec_o !== m_mtvec || mepc_o !== m_mepc) begin
                failures++;
                $display("FAIL rand_state it=%0d irq=%b mtvec=%h mepc=%h required %b/%h/%h", i, irq_pending, mtvec_o, mepc_o, m_irq(), m_mtvec, m_mepc);
            end
        end
        irq_ext = 0; irq_timer = 0; irq_sw = 0;
    endtask

    task automatic test_reset_mid();
        access(12'h340, 2'b01, 0, 32'h1234);
        rst_n = 0;
        access(12'h340, 2'b10, 1, 32'h0);
        checks++;
        if (csr_rvalid !== 1'b0 || csr_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_cycle_req rvalid=%b rdata=%h required 0/00000000", csr_rvalid, csr_rdata);
        end
        rst_n = 1;
        tick();
        checks++;
        if (csr_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_late_rvalid rvalid=%b required 0", csr_rvalid);
        end
        access(12'h340, 2'b10, 1, 32'h0);
        checks++;
        if (csr_rvalid !== 1'b1 || csr_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mscratch rvalid=%b rdata=%h required 1/00000000", csr_rvalid, csr_rdata);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        rst_n = 0; csr_valid = 0; csr_addr = 12'h0; csr_op = 2'b00; csr_nowrite = 0;
        csr_wdata = 32'h0; instr_retire = 0; trap_valid = 0; trap_cause = 32'h0;
        trap_pc = 32'h0; trap_val = 32'h0; mret = 0; irq_ext = 0; irq_timer = 0; irq_sw = 0;
        test_reset();
        test_scratch();
        test_illegal();
        test_fields();
        test_counter_wrap();
        test_irq_trap();
        test_trap_priority();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
